float_accumulator: RTL and testbench

//  Sequential IEEE-754 single-precision accumulator for the kNN distance datapath. Sits downstream
//  of the float subtract/square stage and sums a stream of float32 terms into one distance value.

---
 rtl/float_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_float_accumulator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_accumulator.sv
// rtl/float_accumulator.sv - sequential float32 accumulator with align/add/normalize FSM
// Truncating arithmetic; hidden bit is 0 for exp==0 operands (no denormal exponent fix-up).
module float_accumulator #(
    parameter int CNT_W    = 16,
    parameter bit EXC_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_exception,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_acc;
    logic [31:0]        r_term;
    logic               r_last;
    logic               r_exc;
    logic [CNT_W-1:0]   r_count;
    logic               r_a_sign;
    logic [7:0]         r_a_exp;
    logic [23:0]        r_a_sig;
    logic [23:0]        r_b_sig;
    logic               r_sub;
    logic [24:0]        r_sum;

    logic               w_acc_is_a;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [23:0]        w_a_sig;
    logic [23:0]        w_b_sig;
    logic [7:0]         w_diff;
    logic [23:0]        w_b_aligned;
    logic               w_op_inf;

    logic [4:0]         w_lz;
    logic [4:0]         w_shift;
    logic [8:0]         w_exp_inc;
    logic [7:0]         w_norm_exp;
    logic [22:0]        w_norm_man;
    logic [31:0]        w_norm_acc;
    logic               w_norm_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_ACC;
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_ALIGN;
            end
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = r_last ? S_DONE : S_ACC;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Larger magnitude becomes A, so expA >= expB and the subtraction never goes negative.
    always_comb begin
        w_acc_is_a  = (r_acc[30:0] >= r_term[30:0]);
        w_a         = w_acc_is_a ? r_acc : r_term;
        w_b         = w_acc_is_a ? r_term : r_acc;
        w_a_sig     = {|w_a[30:23], w_a[22:0]};
        w_b_sig     = {|w_b[30:23], w_b[22:0]};
        w_diff      = w_a[30:23] - w_b[30:23];
        w_b_aligned = (w_diff >= 8'd25) ? 24'd0 : (w_b_sig >> w_diff);
        w_op_inf    = (&w_a[30:23]) | (&w_b[30:23]);
    end

    always_comb begin
        w_lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (r_sum[i]) w_lz = 5'(23 - i);
        end
    end

    always_comb begin
        w_exp_inc  = {1'b0, r_a_exp} + 9'd1;
        w_shift    = 5'd0;
        w_norm_exp = 8'd0;
        w_norm_man = 23'd0;
        w_norm_acc = 32'd0;
        w_norm_ovf = 1'b0;
        if (r_sum[24]) begin
            if (w_exp_inc >= 9'd255) w_norm_ovf = 1'b1;
            else                     w_norm_acc = {r_a_sign, w_exp_inc[7:0], r_sum[23:1]};
        end else if (r_sum != 25'd0) begin
            // Left shift may not take the exponent below 1; past that the result is denormal.
            if ({3'b0, w_lz} < r_a_exp) begin
                w_shift    = w_lz;
                w_norm_exp = r_a_exp - {3'b0, w_lz};
            end else begin
                w_shift    = (r_a_exp == 8'd0) ? 5'd0 : 5'(r_a_exp - 8'd1);
                w_norm_exp = 8'd0;
            end
            w_norm_man = r_sum[22:0] << w_shift;
            w_norm_acc = {r_a_sign, w_norm_exp, w_norm_man};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= 32'd0;
            r_term   <= 32'd0;
            r_last   <= 1'b0;
            r_exc    <= 1'b0;
            r_count  <= '0;
            r_a_sign <= 1'b0;
            r_a_exp  <= 8'd0;
            r_a_sig  <= 24'd0;
            r_b_sig  <= 24'd0;
            r_sub    <= 1'b0;
            r_sum    <= 25'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= 32'd0;
                        r_exc   <= 1'b0;
                        r_count <= '0;
                        r_last  <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        r_term <= in_data;
                        r_last <= in_last;
                        if (r_count != '1) r_count <= r_count + CNT_W'(1);
                    end
                end
                S_ALIGN: begin
                    r_a_sign <= w_a[31];
                    r_a_exp  <= w_a[30:23];
                    r_a_sig  <= w_a_sig;
                    r_b_sig  <= w_b_aligned;
                    r_sub    <= w_a[31] ^ w_b[31];
                    if (w_op_inf) r_exc <= 1'b1;
                end
                S_ADD: begin
                    r_sum <= r_sub ? ({1'b0, r_a_sig} - {1'b0, r_b_sig})
                                   : ({1'b0, r_a_sig} + {1'b0, r_b_sig});
                end
                S_NORM: begin
                    r_acc <= w_norm_acc;
                    if (w_norm_ovf) r_exc <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_data      = (EXC_ZERO && r_exc) ? 32'd0 : r_acc;
    assign out_exception = r_exc;
    assign out_count     = r_count;

endmodule

// File: tb/tb_float_accumulator.sv
// tb/tb_float_accumulator.sv - directed self-checking bench for float_accumulator
module tb_float_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'd0;

    logic        in_ready, out_valid, out_exception, busy;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        in_ready2, out_valid2, out_exception2, busy2;
    logic [31:0] out_data2;
    logic [1:0]  out_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    float_accumulator #(.CNT_W(16), .EXC_ZERO(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exception(out_exception), .out_count(out_count), .busy(busy)
    );

    // Narrow-counter, raw-output twin driven by the same stimulus
    float_accumulator #(.CNT_W(2), .EXC_ZERO(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_exception(out_exception2), .out_count(out_count2), .busy(busy2)
    );

    task automatic do_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_term(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic pop_out;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic run_sum(input int n, input logic [31:0] t0, input logic [31:0] t1,
                           input logic [31:0] t2, input logic [31:0] t3, output int lat);
        logic [31:0] t [4];
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        do_start;
        for (int i = 0; i < n; i++) send_term(t[i], (i == n - 1));
        wait_out(lat);
    endtask

    task automatic test_reset;
        checks++;
        if ({in_ready, out_valid, out_exception, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {in_ready, out_valid, out_exception, busy});
        end
        checks++;
        if (out_data !== 32'd0 || out_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h count=%0d required 0/0", out_data, out_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b in_ready=%0b required 0/0", busy, in_ready);
        end
    endtask

    task automatic test_basic;
        int lat;
        run_sum(3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d required 4", lat); end
        checks++;
        if (out_data !== 32'h40C00000) begin errors++; $display("FAIL basic_sum: got %h required 40C00000", out_data); end
        checks++;
        if (out_count !== 16'd3 || out_exception !== 1'b0) begin
            errors++; $display("FAIL basic_count_exc: count=%0d exc=%0b required 3/0", out_count, out_exception);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_done_flags: busy=%0b in_ready=%0b required 1/0", busy, in_ready);
        end
        pop_out;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: out_valid=%0b busy=%0b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_cancel;
        int lat;
        run_sum(2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h00000000 || out_exception !== 1'b0) begin
            errors++; $display("FAIL cancel_zero: data=%h exc=%0b required 00000000/0", out_data, out_exception);
        end
        pop_out;
        run_sum(2, 32'h3F800000, 32'hBE800000, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h3F400000) begin errors++; $display("FAIL sub_norm: got %h required 3F400000", out_data); end
        pop_out;
        run_sum(2, 32'h3F800000, 32'hC0000000, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'hBF800000) begin errors++; $display("FAIL sub_negative: got %h required BF800000", out_data); end
        pop_out;
    endtask

    task automatic test_exception;
        int lat;
        run_sum(3, 32'h40A00000, 32'h7F800000, 32'h3F800000, 32'h0, lat);
        checks++;
        if (out_exception !== 1'b1 || out_data !== 32'h0 || out_count !== 16'd3) begin
            errors++; $display("FAIL inf_operand: exc=%0b data=%h count=%0d required 1/00000000/3",
                               out_exception, out_data, out_count);
        end
        checks++;
        if (out_exception2 !== 1'b1 || out_data2 !== 32'h7F800000) begin
            errors++; $display("FAIL inf_raw: exc=%0b data=%h required 1/7F800000", out_exception2, out_data2);
        end
        pop_out;
        run_sum(2, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0, lat);
        checks++;
        if (out_exception !== 1'b1 || out_data !== 32'h0 || out_data2 !== 32'h0) begin
            errors++; $display("FAIL overflow: exc=%0b data=%h raw=%h required 1/0/0", out_exception, out_data, out_data2);
        end
        pop_out;
        run_sum(1, 32'h3F800000, 32'h0, 32'h0, 32'h0, lat);
        checks++;
        if (out_exception !== 1'b0 || out_data !== 32'h3F800000) begin
            errors++; $display("FAIL exc_cleared: exc=%0b data=%h required 0/3F800000", out_exception, out_data);
        end
        pop_out;
    endtask

    task automatic test_first_last;
        int lat;
        run_sum(1, 32'h80000000, 32'h0, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h00000000 || out_count !== 16'd1) begin
            errors++; $display("FAIL neg_zero: data=%h count=%0d required 00000000/1", out_data, out_count);
        end
        pop_out;
    endtask

    task automatic test_boundary;
        int lat;
        run_sum(2, 32'h4C000000, 32'h3F800000, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h4C000000) begin errors++; $display("FAIL diff25: got %h required 4C000000", out_data); end
        pop_out;
        run_sum(2, 32'h4B000000, 32'h3F800000, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h4B000001) begin errors++; $display("FAIL diff23: got %h required 4B000001", out_data); end
        pop_out;
        run_sum(2, 32'h00800000, 32'h80400000, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h00600000) begin errors++; $display("FAIL denorm_limit: got %h required 00600000", out_data); end
        pop_out;
    endtask

    task automatic test_saturation;
        int lat;
        run_sum(4, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, lat);
        checks++;
        if (out_data !== 32'h40800000 || out_count !== 16'd4) begin
            errors++; $display("FAIL four_terms: data=%h count=%0d required 40800000/4", out_data, out_count);
        end
        checks++;
        if (out_count2 !== 2'd3) begin errors++; $display("FAIL count_saturate: got %0d required 3", out_count2); end
        pop_out;
    endtask

    task automatic test_start_ignored;
        int lat;
        do_start;
        send_term(32'h3F800000, 1'b0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_term(32'h3F800000, 1'b1);
        wait_out(lat);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (out_data !== 32'h40000000 || out_count !== 16'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL start_ignored: data=%h count=%0d valid=%0b required 40000000/2/1",
                               out_data, out_count, out_valid);
        end
        pop_out;
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        bad = 0;
        run_sum(1, 32'h40400000, 32'h0, 32'h0, 32'h0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 32'h40400000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL backpressure_hold: unstable cycles=%0d required 0 (valid=%0b data=%h)",
                               bad, out_valid, out_data);
        end
        pop_out;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: valid=%0b busy=%0b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        do_start;
        send_term(32'h40000000, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_exception, busy} !== 4'b0000 || out_data !== 32'd0 || out_count !== 16'd0) begin
            errors++; $display("FAIL reset_mid: flags=%b data=%h count=%0d required 0000/0/0",
                               {in_ready, out_valid, out_exception, busy}, out_data, out_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_hold: valid=%0b busy=%0b required 0/0", out_valid, busy);
        end
        rst_n = 1'b1;
        run_sum(1, 32'h40000000, 32'h0, 32'h0, 32'h0, lat);
        checks++;
        if (out_data !== 32'h40000000 || out_count !== 16'd1) begin
            errors++; $display("FAIL after_reset_sum: data=%h count=%0d required 40000000/1", out_data, out_count);
        end
        pop_out;
    endtask

    initial begin
        #12;
        test_reset;
        test_basic;
        test_cancel;
        test_exception;
        test_first_last;
        test_boundary;
        test_saturation;
        test_start_ignored;
        test_backpressure;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
